cmp_result_tracker: RTL and testbench



---
 rtl/cmp_pkg.sv | 17 +
 rtl/sat_counter.sv | 33 +++
 rtl/cmp_result_tracker.sv | 117 +++++++++++
 tb/tb_cmp_result_tracker.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and defaults for the comparator result tracker
//
// Purpose: tracker state encoding and default parameter values, imported by
// cmp_result_tracker and its sub-blocks.
package cmp_pkg;

  // Tracker states: no accepted sample yet, counting, equal-run locked.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam int CW_DEF       = 8;
  localparam int LOCK_RUN_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and hold
//
// Purpose: W-bit counter that increments on inc, sticks at 2^W-1, never wraps.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (highest priority after reset)
//   hold       : freeze the count this cycle
//   inc        : increment by one unless saturated
//   count      : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         hold,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold && inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_result_tracker.sv
// rtl/cmp_result_tracker.sv - outcome counters and equal-run lock tracker for a magnitude comparator
//
// Purpose: samples the comparator g/l/e flags under in_valid, counts each
// outcome (saturating), tracks the current run of consecutive equal results
// and locks once the run reaches LOCK_RUN. All outputs come from registers.
// Optional feature macro: CMP_CHECK_EN (sticky err on non-one-hot samples).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, g, l, e   : comparator outcome flags and their strobe
//   clr                 : synchronous clear of counters, state and err
//   cnt_g, cnt_l, cnt_e : accepted sample counts per outcome
//   run_e               : current consecutive-equal run
//   lock, busy, err     : LOCK state, TRACK/LOCK state, sticky illegal flag
module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int LOCK_RUN = LOCK_RUN_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          g,
  input  logic          l,
  input  logic          e,
  input  logic          clr,
  output logic [CW-1:0] cnt_g,
  output logic [CW-1:0] cnt_l,
  output logic [CW-1:0] cnt_e,
  output logic [CW-1:0] run_e,
  output logic          lock,
  output logic          busy,
  output logic          err
);

  localparam logic [CW:0] LOCK_THR = (CW+1)'(LOCK_RUN);

  state_t state, state_n;

  logic        one_hot;
  logic        acc;
  logic        acc_g, acc_l, acc_e;
  logic [CW:0] run_inc;
  logic        run_reach;

  // Exactly one of the three flags set; clr discards a coincident sample.
  assign one_hot = (g ^ l ^ e) & ~(g & l & e);
  assign acc     = in_valid & one_hot & ~clr;
  assign acc_g   = acc & g;
  assign acc_l   = acc & l;
  assign acc_e   = acc & e;

  // One bit wider so the compare is correct even when run_e is saturated.
  assign run_inc   = {1'b0, run_e} + {{CW{1'b0}}, 1'b1};
  assign run_reach = acc_e && (run_inc >= LOCK_THR);

  sat_counter #(.W(CW)) u_cnt_g (
    .clk(clk), .rst_n(rst_n), .clr(clr), .hold(~in_valid), .inc(acc_g), .count(cnt_g)
  );

  sat_counter #(.W(CW)) u_cnt_l (
    .clk(clk), .rst_n(rst_n), .clr(clr), .hold(~in_valid), .inc(acc_l), .count(cnt_l)
  );

  sat_counter #(.W(CW)) u_cnt_e (
    .clk(clk), .rst_n(rst_n), .clr(clr), .hold(~in_valid), .inc(acc_e), .count(cnt_e)
  );

  // An accepted g or l breaks the equal run.
  sat_counter #(.W(CW)) u_run_e (
    .clk(clk), .rst_n(rst_n), .clr(clr | acc_g | acc_l), .hold(~in_valid), .inc(acc_e),
    .count(run_e)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (clr) begin
      state_n = IDLE;
    end else if (acc) begin
      case (state)
        IDLE, TRACK: state_n = run_reach ? LOCK : TRACK;
        LOCK:        state_n = acc_e ? LOCK : TRACK;
        default:     state_n = IDLE;
      endcase
    end
  end

  assign lock = (state == LOCK);
  assign busy = (state != IDLE);

`ifdef CMP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (clr) begin
      err_q <= 1'b0;
    end else if (in_valid && !one_hot) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb/tb_cmp_result_tracker.sv - self-checking bench for cmp_result_tracker
module tb_cmp_result_tracker;

  localparam int CW       = 4;
  localparam int LOCK_RUN = 4;
  localparam int MAXV     = (1 << CW) - 1;
`ifdef CMP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, g = 1'b0, l = 1'b0, e = 1'b0, clr = 1'b0;
  logic [CW-1:0] cnt_g, cnt_l, cnt_e, run_e;
  logic          lock, busy, err;

  int nchk = 0;
  int nerr = 0;

  // Reference model: unbounded tallies, saturation applied only when compared.
  int mg, ml, me, mrun;
  bit mbusy, merr;

  cmp_result_tracker #(.CW(CW), .LOCK_RUN(LOCK_RUN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .g(g), .l(l), .e(e), .clr(clr),
    .cnt_g(cnt_g), .cnt_l(cnt_l), .cnt_e(cnt_e), .run_e(run_e),
    .lock(lock), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, fg, fl, fe, c;
    int   eg, el, ee, er;
    bit   elk, ebs, eer;
  } vec_t;

  vec_t vecs[10];

  function automatic int sat(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  task automatic model_reset();
    mg = 0; ml = 0; me = 0; mrun = 0; mbusy = 0; merr = 0;
  endtask

  task automatic model_step(input bit v, input bit fg, input bit fl, input bit fe, input bit c);
    int n;
    n = fg + fl + fe;
    if (c) begin
      model_reset();
    end else if (v && n == 1) begin
      mbusy = 1;
      if (fg) begin mg++; mrun = 0; end
      if (fl) begin ml++; mrun = 0; end
      if (fe) begin me++; mrun++; end
    end else if (v && CHK) begin
      merr = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance past the edge, update the model.
  task automatic drive(input bit v, input bit fg, input bit fl, input bit fe, input bit c);
    in_valid = v; g = fg; l = fl; e = fe; clr = c;
    @(posedge clk);
    model_step(v, fg, fl, fe, c);
    #1;
    in_valid = 1'b0; g = 1'b0; l = 1'b0; e = 1'b0; clr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cnt_g"}, 32'(cnt_g), 32'(sat(mg)));
    chk({tag, ".cnt_l"}, 32'(cnt_l), 32'(sat(ml)));
    chk({tag, ".cnt_e"}, 32'(cnt_e), 32'(sat(me)));
    chk({tag, ".run_e"}, 32'(run_e), 32'(sat(mrun)));
    chk({tag, ".lock"},  32'(lock),  32'(mrun >= LOCK_RUN));
    chk({tag, ".busy"},  32'(busy),  32'(mbusy));
    chk({tag, ".err"},   32'(err),   32'(merr));
  endtask

  initial begin
    //            v  g  l  e  c   eg el ee er lock busy err
    vecs[0] = '{1, 0, 1, 0, 0,  0, 1, 0, 0, 0, 1, 0};
    vecs[1] = '{1, 0, 0, 1, 0,  0, 1, 1, 1, 0, 1, 0};
    vecs[2] = '{1, 0, 0, 1, 0,  0, 1, 2, 2, 0, 1, 0};
    vecs[3] = '{1, 0, 0, 1, 0,  0, 1, 3, 3, 0, 1, 0};
    vecs[4] = '{1, 0, 0, 1, 0,  0, 1, 4, 4, 1, 1, 0};
    vecs[5] = '{1, 1, 0, 0, 0,  1, 1, 4, 0, 0, 1, 0};
    vecs[6] = '{1, 1, 0, 1, 0,  1, 1, 4, 0, 0, 1, CHK};
    vecs[7] = '{0, 0, 0, 1, 0,  1, 1, 4, 0, 0, 1, CHK};
    vecs[8] = '{1, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0};
    vecs[9] = '{1, 0, 0, 1, 0,  0, 0, 1, 1, 0, 1, 0};

    model_reset();
    #12;
    chk("reset.cnt_g", 32'(cnt_g), 0);
    chk("reset.run_e", 32'(run_e), 0);
    chk("reset.lock",  32'(lock), 0);
    chk("reset.busy",  32'(busy), 0);
    chk("reset.err",   32'(err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed sequence: l sample, lock after 4 e, g drops lock, illegal, idle, clr.
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].fg, vecs[i].fl, vecs[i].fe, vecs[i].c);
      chk($sformatf("vec%0d.cnt_g", i), 32'(cnt_g), 32'(vecs[i].eg));
      chk($sformatf("vec%0d.cnt_l", i), 32'(cnt_l), 32'(vecs[i].el));
      chk($sformatf("vec%0d.cnt_e", i), 32'(cnt_e), 32'(vecs[i].ee));
      chk($sformatf("vec%0d.run_e", i), 32'(run_e), 32'(vecs[i].er));
      chk($sformatf("vec%0d.lock", i),  32'(lock),  32'(vecs[i].elk));
      chk($sformatf("vec%0d.busy", i),  32'(busy),  32'(vecs[i].ebs));
      chk($sformatf("vec%0d.err", i),   32'(err),   32'(vecs[i].eer));
    end

    // Saturation: 20 g samples must stop at 15.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 0);
    chk("sat.cnt_g", 32'(cnt_g), 32'(MAXV));
    check_model("sat");

    // Long equal run: run_e saturates while lock holds.
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 1, 0);
    chk("runsat.run_e", 32'(run_e), 32'(MAXV));
    chk("runsat.lock", 32'(lock), 1);
    check_model("runsat");

    // Asynchronous reset between edges while locked.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 0);
    chk("prerst.lock", 32'(lock), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.cnt_e", 32'(cnt_e), 0);
    chk("arst.run_e", 32'(run_e), 0);
    chk("arst.lock",  32'(lock), 0);
    chk("arst.busy",  32'(busy), 0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_model("postrst");

    // Randomized traffic against the model, including illegal flags and clears.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] f;
      bit v, c;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: f = 3'b001;
        3, 4, 5, 6: f = 3'b100;
        7: f = 3'b010;
        default: f = 3'($urandom);
      endcase
      drive(v, f[2], f[1], f[0], c);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
